// File: rtl/sentinel_key_conditioner.sv
// Sentinel key conditioner: synchronise and debounce the DIP key, commit it to the
// validator, and enforce a brute-force lockout. Optional tamper tally: SENTINEL_TAMPER_LOG_EN.
module sentinel_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int AUTH_LATENCY    = 1,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] key_raw,
  input  logic       auth_ok,
  output logic [7:0] key_out,
  output logic       key_valid,
  output logic       locked_out,
  output logic [2:0] fail_count,
  output logic [7:0] tamper_count
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int TMR_W  = $clog2(LOCKOUT_CYCLES);
  localparam int WAIT_W = $clog2(AUTH_LATENCY + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_INIT   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(AUTH_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(1);
  localparam logic [2:0]        FAIL_MAX   = 3'(MAX_FAILS);
  localparam logic [3:0]        FAIL_LIMIT = 4'(MAX_FAILS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EVAL    = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  logic [7:0]        sync1_q, sync2_q;
  logic [7:0]        cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        key_q, key_d;
  logic              valid_q, valid_d;
  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [2:0]        fail_q, fail_d;
  logic              locked_q, locked_d;
  logic [3:0]        fail_inc;

  assign fail_inc = {1'b0, fail_q} + 4'd1;

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    valid_d  = 1'b0;
    state_d  = state_q;
    wait_d   = wait_q;
    timer_d  = timer_q;
    fail_d   = fail_q;
    locked_d = locked_q;

    if (ena) begin
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      // A stable candidate waiting outside IDLE simply stays pending here.
      case (state_q)
        ST_IDLE: begin
          if ((cnt_q == CNT_MAX) && (cand_q != key_q)) begin
            key_d   = cand_q;
            valid_d = 1'b1;
            wait_d  = WAIT_INIT;
            state_d = ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (wait_q == WAIT_LAST) begin
            wait_d = '0;
            if (auth_ok) begin
              fail_d  = '0;
              state_d = ST_IDLE;
            end else if (fail_inc < FAIL_LIMIT) begin
              fail_d  = fail_inc[2:0];
              state_d = ST_IDLE;
            end else begin
              fail_d   = FAIL_MAX;
              key_d    = 8'h00;
              locked_d = 1'b1;
              timer_d  = TMR_INIT;
              state_d  = ST_LOCKOUT;
            end
          end else begin
            wait_d = wait_q - WAIT_LAST;
          end
        end
        ST_LOCKOUT: begin
          if (timer_q == '0) begin
            fail_d   = '0;
            locked_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
      cand_q   <= 8'h00;
      cnt_q    <= '0;
      key_q    <= 8'h00;
      valid_q  <= 1'b0;
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      timer_q  <= '0;
      fail_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
      state_q  <= state_d;
      wait_q   <= wait_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      locked_q <= locked_d;
    end
  end

  assign key_out    = key_q;
  assign key_valid  = valid_q;
  assign locked_out = locked_q;
  assign fail_count = fail_q;

`ifdef SENTINEL_TAMPER_LOG_EN
  // Lifetime tally survives success and lockout expiry; only reset clears it.
  logic [7:0] tamper_q, tamper_d;
  logic       fail_evt;

  assign fail_evt = ena && (state_q == ST_EVAL) && (wait_q == WAIT_LAST) && !auth_ok;

  always_comb begin
    tamper_d = tamper_q;
    if (fail_evt && (tamper_q != 8'hFF)) tamper_d = tamper_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tamper_q <= 8'h00;
    else        tamper_q <= tamper_d;
  end

  assign tamper_count = tamper_q;
`else
  assign tamper_count = 8'h00;
`endif

endmodule

// File: tb/tb_sentinel_key_conditioner.sv
// Self-checking bench for sentinel_key_conditioner: directed scenarios plus a
// randomized phase, all checked every cycle against a window/countdown model.
module tb_sentinel_key_conditioner;

  localparam int DEB  = 4;
  localparam int LAT  = 1;
  localparam int MAXF = 3;
  localparam int LOCK = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] key_raw;
  logic       auth_ok;
  logic [7:0] key_out;
  logic       key_valid;
  logic       locked_out;
  logic [2:0] fail_count;
  logic [7:0] tamper_count;

  int checks = 0;
  int errors = 0;

  sentinel_key_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTH_LATENCY   (LAT),
    .MAX_FAILS      (MAXF),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .key_raw     (key_raw),
    .auth_ok     (auth_ok),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .locked_out  (locked_out),
    .fail_count  (fail_count),
    .tamper_count(tamper_count)
  );

  always #5 clk = ~clk;

  // Model: a key commits once the last DEB enabled synchronised samples agree and
  // differ from the committed key; evaluation and lockout are plain countdowns.
  logic [7:0] raw_pipe[$];
  logic [7:0] seen[$];
  logic [7:0] m_sync;
  logic [7:0] m_key;
  bit         m_valid;
  bit         m_locked;
  int         m_fails;
  int         m_tamper;
  int         eval_left;
  int         lock_left;

  function automatic bit window_stable();
    if (seen.size() < DEB) return 1'b0;
    for (int i = 1; i < seen.size(); i++)
      if (seen[i] != seen[0]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_tamper();
`ifdef SENTINEL_TAMPER_LOG_EN
    return m_tamper;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_pipe.delete();
      raw_pipe.push_back(8'h00);
      raw_pipe.push_back(8'h00);
      seen.delete();
      m_key     = 8'h00;
      m_valid   = 1'b0;
      m_locked  = 1'b0;
      m_fails   = 0;
      m_tamper  = 0;
      eval_left = 0;
      lock_left = 0;
    end else begin
      m_sync = raw_pipe.pop_front();
      raw_pipe.push_back(key_raw);
      m_valid = 1'b0;
      if (ena) begin
        if (lock_left > 0) begin
          lock_left--;
          if (lock_left == 0) begin
            m_locked = 1'b0;
            m_fails  = 0;
          end
        end else if (eval_left > 0) begin
          eval_left--;
          if (eval_left == 0) begin
            if (auth_ok) begin
              m_fails = 0;
            end else begin
              if (m_tamper < 255) m_tamper++;
              m_fails++;
              if (m_fails == MAXF) begin
                lock_left = LOCK;
                m_locked  = 1'b1;
                m_key     = 8'h00;
              end
            end
          end
        end else if (window_stable() && (seen[0] != m_key)) begin
          m_key     = seen[0];
          m_valid   = 1'b1;
          eval_left = LAT;
        end
        seen.push_back(m_sync);
        if (seen.size() > DEB) void'(seen.pop_front());
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_output("key_out",      32'(key_out),      32'(m_key));
      check_output("key_valid",    32'(key_valid),    32'(m_valid));
      check_output("locked_out",   32'(locked_out),   32'(m_locked));
      check_output("fail_count",   32'(fail_count),   32'(m_fails));
      check_output("tamper_count", 32'(tamper_count), 32'(exp_tamper()));
    end
  end

  task automatic wait_valid(input int max_edges, output int edges);
    edges = 0;
    while (edges <= max_edges) begin
      @(negedge clk);
      edges++;
      if (key_valid) break;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] key, input logic ok);
    key_raw = key;
    auth_ok = ok;
  endtask

  // Commit one key, let the validator answer, and pin fail_count afterwards.
  task automatic commit_and_judge(input logic [7:0] key, input logic ok,
                                  input int exp_fails, input string tag);
    int n;
    apply_stimulus(key, ok);
    wait_valid(20, n);
    check_output({tag, "_latency"}, 32'(n), 32'(DEB + 3));
    check_output({tag, "_key"}, 32'(key_out), 32'(key));
    @(negedge clk);
    check_output({tag, "_fails"}, 32'(fail_count), 32'(exp_fails));
  endtask

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0;
    ena   = 1'b1;
    apply_stimulus(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check_output("rst_key_out",    32'(key_out),      32'h0);
    check_output("rst_key_valid",  32'(key_valid),    32'h0);
    check_output("rst_locked",     32'(locked_out),   32'h0);
    check_output("rst_fail_count", 32'(fail_count),   32'h0);
    check_output("rst_tamper",     32'(tamper_count), 32'h0);

    // Scenario 1: single pulse on edge 7, none afterwards.
    rst_n = 1'b1;
    apply_stimulus(8'hB6, 1'b1);
    wait_valid(12, n);
    check_output("s1_latency", 32'(n), 32'd7);
    check_output("s1_key_out", 32'(key_out), 32'hB6);
    check_output("s1_model_key", 32'(m_key), 32'hB6);
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    check_output("s1_repeat_pulses", 32'(pulses), 32'd0);

    // Scenario 2: bouncing input never commits, final value commits after 7 edges.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      key_raw = (i % 2 == 0) ? 8'h00 : 8'hB6;
      repeat (2) begin
        @(negedge clk);
        if (key_valid) pulses++;
      end
    end
    check_output("s2_bounce_pulses", 32'(pulses), 32'd0);
    key_raw = 8'h5A;
    wait_valid(20, n);
    check_output("s2_latency", 32'(n), 32'd7);
    check_output("s2_key_out", 32'(key_out), 32'h5A);
    repeat (2) @(negedge clk);

    // Scenario 3: three failures lead to lockout.
    commit_and_judge(8'h11, 1'b0, 1, "s3_a");
    commit_and_judge(8'h22, 1'b0, 2, "s3_b");
    commit_and_judge(8'h33, 1'b0, 3, "s3_c");
    check_output("s3_locked", 32'(locked_out), 32'd1);
    check_output("s3_null_key", 32'(key_out), 32'h00);
    check_output("s3_model_locked", 32'(m_locked), 32'd1);
`ifdef SENTINEL_TAMPER_LOG_EN
    check_output("s3_tamper", 32'(tamper_count), 32'd3);
`endif

    // Scenario 4: a key held through lockout commits right after it ends.
    apply_stimulus(8'hB6, 1'b1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!locked_out) break;
      n++;
    end
    check_output("s4_lock_cycles", 32'(n), 32'(LOCK));
    check_output("s4_fails_cleared", 32'(fail_count), 32'd0);
    @(negedge clk);
    check_output("s4_post_lock_valid", 32'(key_valid), 32'd1);
    check_output("s4_post_lock_key", 32'(key_out), 32'hB6);
    @(negedge clk);
    check_output("s4_success_fails", 32'(fail_count), 32'd0);

    // Scenario 5: two failures then success, no lockout.
    commit_and_judge(8'h44, 1'b0, 1, "s5_a");
    commit_and_judge(8'h55, 1'b0, 2, "s5_b");
    commit_and_judge(8'h66, 1'b1, 0, "s5_c");
    check_output("s5_not_locked", 32'(locked_out), 32'd0);

    // ena drops exactly when the pulse is due; commit waits for ena to return.
    apply_stimulus(8'h77, 1'b1);
    repeat (6) @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    check_output("ena_suppressed", 32'(key_valid), 32'd0);
    check_output("ena_key_held", 32'(key_out), 32'h66);
    ena = 1'b1;
    @(negedge clk);
    check_output("ena_resume_valid", 32'(key_valid), 32'd1);
    check_output("ena_resume_key", 32'(key_out), 32'h77);
    @(negedge clk);

    // Scenario 6: asynchronous reset in the middle of a lockout.
    commit_and_judge(8'h81, 1'b0, 1, "s6_a");
    commit_and_judge(8'h82, 1'b0, 2, "s6_b");
    commit_and_judge(8'h83, 1'b0, 3, "s6_c");
    repeat (4) @(negedge clk);
    check_output("s6_locked", 32'(locked_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("s6_async_key", 32'(key_out), 32'h0);
    check_output("s6_async_valid", 32'(key_valid), 32'h0);
    check_output("s6_async_locked", 32'(locked_out), 32'h0);
    check_output("s6_async_fails", 32'(fail_count), 32'h0);
    check_output("s6_async_tamper", 32'(tamper_count), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("s6_unlocked", 32'(locked_out), 32'd0);
    check_output("s6_tamper_cleared", 32'(tamper_count), 32'd0);

    // Randomized phase: keys from a small pool, random holds, verdicts and ena.
    for (int seg = 0; seg < 120; seg++) begin
      int hold;
      hold = $urandom_range(1, 9);
      if ($urandom_range(0, 3) == 0) key_raw = 8'($urandom);
      else                           key_raw = 8'($urandom_range(0, 3) * 8'h41);
      repeat (hold) begin
        auth_ok = 1'($urandom);
        ena     = ($urandom_range(0, 9) != 0);
        @(negedge clk);
      end
    end
    ena = 1'b1;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sentinel_key_conditioner.md
Name: sentinel_key_conditioner

Overview:
Upstream conditioning stage for the Sentinel lock. It sits between the UI DIP-switch pins and the key validator.
- Synchronises and debounces the raw 8-bit key.
- Presents a stable committed key with a one-cycle commit strobe.
- Counts failed authorisations from the validator's verdict and enforces a timed brute-force lockout, during which the validator sees a forced null key.

Parameters:
DEBOUNCE_CYCLES, 1024, cycles a synchronised value must hold before commit (≥2)
AUTH_LATENCY, 1, cycles from key_valid until auth_ok is valid (≥1)
MAX_FAILS, 3, consecutive failed commits that trigger lockout (1..7)
LOCKOUT_CYCLES, 65536, lockout duration in clk cycles (≥2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  power-state enable; low freezes all counters and the FSM
key_raw  in  8  raw DIP-switch key (ui_in)
auth_ok  in  1  validator verdict for key_out
key_out  out  8  committed key to validator
key_valid  out  1  one-cycle pulse when key_out takes a new committed value
locked_out  out  1  high for the whole lockout period
fail_count  out  3  consecutive failures since last success or lockout expiry
tamper_count  out  8  lifetime failure tally (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: all outputs 0. Sync flops, candidate and committed key are 0x00. Counters are 0. FSM is IDLE.
- Synchroniser: two flops on key_raw. No logic between the stages.
- Debounce:
  - If sync output ≠ candidate: candidate ← sync, cnt ← 0.
  - Otherwise cnt increments, saturating at DEBOUNCE_CYCLES-1.
- Commit: occurs in IDLE only, when cnt == DEBOUNCE_CYCLES-1 and candidate ≠ key_out. Then key_out ← candidate and key_valid = 1 for exactly one cycle.
  - No repeat pulse while the value is unchanged.
  - A commit condition that arises in EVAL or LOCKOUT is deferred, not lost, unless the value bounces.
- Latency: counting the edge that first samples a new key_raw as edge 1, key_valid/key_out update on edge DEBOUNCE_CYCLES+3.
- Bounce: any change restarts the count. A value that returns to the committed key never pulses.
- FSM states: IDLE, EVAL, LOCKOUT.
  - IDLE → EVAL on commit. A wait counter is loaded with AUTH_LATENCY.
  - EVAL:
    - Decrement the wait counter.
    - When it expires, sample auth_ok.
    - auth_ok = 1: fail_count ← 0, go to IDLE.
    - auth_ok = 0, fail_count+1 < MAX_FAILS: fail_count++, go to IDLE.
    - auth_ok = 0, fail_count+1 == MAX_FAILS: fail_count ← MAX_FAILS, go to LOCKOUT, timer ← LOCKOUT_CYCLES-1.
  - LOCKOUT:
    - key_out forced 0x00 on entry. locked_out = 1. No commits. Debounce keeps tracking.
    - Timer decrements each cycle.
    - At timer == 0: go to IDLE, fail_count ← 0, locked_out ← 0.
    - A non-null key already stable on key_raw commits on the first IDLE cycle.
- ena = 0: sync still samples, but the debounce counter, wait counter, lockout timer and FSM hold. key_valid = 0. Outputs retain their values.
- ena fall while key_valid would pulse: the pulse is suppressed and the commit is taken on ena return.
- auth_ok is ignored outside the EVAL sample cycle.
- Reset mid-lockout clears the lockout completely (accepted: no non-volatile state).
- fail_count saturates at MAX_FAILS. It never wraps.

Optional Feature:
- Macro: SENTINEL_TAMPER_LOG_EN.
- Defined: tamper_count increments on every failed EVAL sample and saturates at 0xFF. It is cleared only by rst_n and is not cleared by success or lockout expiry.
- Undefined: tamper_count is tied to 0x00 and no register is inferred.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, AUTH_LATENCY=1, MAX_FAILS=3, LOCKOUT_CYCLES=16, ena=1.
1. Reset, then key_raw=0xB6 held -> key_valid single pulse on edge 7; key_out=0xB6; no second pulse over 50 cycles.
2. key_raw toggles 0xB6/0x00 every 2 cycles for 20 cycles, then holds 0x5A -> no pulse during toggling; one pulse with key_out=0x5A 7 edges after the final change.
3. Three commits 0x11, 0x22, 0x33, each answered auth_ok=0 -> fail_count 1, 2, 3; locked_out rises the cycle after the third EVAL; key_out=0x00; stays locked exactly 16 cycles, then fail_count=0.
4. During lockout key_raw=0xB6 stable -> no key_valid while locked; pulse with key_out=0xB6 on the first IDLE cycle; auth_ok=1 -> fail_count=0.
5. Two failures, then success -> fail_count 2 then 0; locked_out never asserts.
6. rst_n low for 1 cycle mid-lockout -> all outputs 0x00/0 immediately (async); lockout cleared. With SENTINEL_TAMPER_LOG_EN, before the reset tamper_count=3 after scenario 3; after the reset it reads 0.
